// File: rtl/loader_pkg.sv
// Shared definitions for the program loader: FSM states, abort codes, header layout.
// No ports; header word = [31:24] magic, [23:12] instruction count, [11:0] data count.
// Helper functions split a header word and classify it against the configured limits.
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_INSTR,
    ST_DATA,
    ST_START,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_MAGIC   = 2'd1;
  localparam logic [1:0] ERR_COUNT   = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam int HDR_MAGIC_MSB  = 31;
  localparam int HDR_MAGIC_LSB  = 24;
  localparam int HDR_NINSTR_MSB = 23;
  localparam int HDR_NINSTR_LSB = 12;
  localparam int HDR_NDATA_MSB  = 11;
  localparam int HDR_NDATA_LSB  = 0;

  localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;

  // Word index / count width used throughout the loader.
  localparam int CNT_W = 12;

  typedef struct packed {
    logic [7:0]       magic;
    logic [CNT_W-1:0] n_instr;
    logic [CNT_W-1:0] n_data;
  } hdr_t;

  function automatic hdr_t unpack_hdr(input logic [31:0] w);
    hdr_t h;
    h.magic   = w[HDR_MAGIC_MSB:HDR_MAGIC_LSB];
    h.n_instr = w[HDR_NINSTR_MSB:HDR_NINSTR_LSB];
    h.n_data  = w[HDR_NDATA_MSB:HDR_NDATA_LSB];
    return h;
  endfunction

  // Magic is checked first, so a frame with both a bad magic and bad counts
  // reports the magic error.
  function automatic logic [1:0] check_hdr(input hdr_t        h,
                                           input logic [7:0]  magic,
                                           input int unsigned imem_depth,
                                           input int unsigned dmem_depth);
    logic [1:0] code;
    code = ERR_NONE;
    if (h.magic != magic) begin
      code = ERR_MAGIC;
    end else if ((h.n_instr == '0) ||
                 (32'(h.n_instr) > imem_depth) ||
                 (32'(h.n_data) > dmem_depth)) begin
      code = ERR_COUNT;
    end
    return code;
  endfunction

endpackage

// File: rtl/loader_timeout_ctr.sv
// Idle-cycle counter for the loader stream; flags the cycle that would make it reach TIMEOUT.
// Ports: clk/rst; clear (highest priority) zeroes the count, enable counts one idle cycle,
// expired is combinational: high in the TIMEOUT-th consecutive enabled cycle after a clear.
module loader_timeout_ctr #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CW'(1);
    end
  end

  // Decoded one cycle early so the owner can leave its state on the very edge
  // at which the count would reach TIMEOUT.
  assign expired = enable && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/program_loader.sv
// Loads a framed word stream (header, N instruction words, M data words) into I/D caches,
// holding the core in reset meanwhile and then pulsing core_start.
// Latency: each accepted payload word appears as a one-cycle registered cache write on the
// next cycle. Backpressure: s_ready is high only while a header or payload word is expected.
// Ports: clk/rst; load_req starts a session; s_data/s_valid/s_ready stream input;
// imem_*/dmem_* cache write ports; core_rst/core_start core control;
// busy/done/err/err_code session status (done/err sticky until the next load_req).
module program_loader
  import loader_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = 256,
  parameter int unsigned DMEM_DEPTH = 256,
  parameter int unsigned DATA_BASE  = 0,
  parameter logic [7:0]  MAGIC      = MAGIC_DEFAULT,
  parameter int unsigned TIMEOUT    = 1024,
  parameter int unsigned START_HOLD = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_req,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        imem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic        dmem_we,
  output logic        core_rst,
  output logic        core_start,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code
);

  localparam int HOLD_W = $clog2(START_HOLD + 1);

  state_t           state;
  state_t           state_next;
  hdr_t             hdr_in;
  logic [1:0]       hdr_code;
  logic [1:0]       err_code_next;
  logic [CNT_W-1:0] n_instr;
  logic [CNT_W-1:0] n_data;
  logic [CNT_W-1:0] word_idx;
  logic [HOLD_W-1:0] hold_cnt;
  logic             in_stream;
  logic             accept;
  logic             tmo_clear;
  logic             tmo_en;
  logic             tmo_expired;

  assign in_stream = (state == ST_HDR) || (state == ST_INSTR) || (state == ST_DATA);
  assign s_ready   = in_stream;
  assign accept    = s_valid && s_ready;

  assign hdr_in   = unpack_hdr(s_data);
  assign hdr_code = check_hdr(hdr_in, MAGIC, IMEM_DEPTH, DMEM_DEPTH);

  // Idle time is measured per word: any accept or any state change restarts it.
  assign tmo_clear = accept || (state_next != state);
  assign tmo_en    = in_stream && !accept;

  loader_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (tmo_clear),
    .enable  (tmo_en),
    .expired (tmo_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next    = state;
    err_code_next = ERR_NONE;
    busy          = 1'b0;
    core_rst      = 1'b0;
    core_start    = 1'b0;
    done          = 1'b0;
    err           = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (load_req) state_next = ST_HDR;
      end

      ST_HDR: begin
        busy     = 1'b1;
        core_rst = 1'b1;
        if (tmo_expired) begin
          state_next    = ST_ERR;
          err_code_next = ERR_TIMEOUT;
        end else if (s_valid) begin
          if (hdr_code != ERR_NONE) begin
            state_next    = ST_ERR;
            err_code_next = hdr_code;
          end else begin
            state_next = ST_INSTR;
          end
        end
      end

      ST_INSTR: begin
        busy     = 1'b1;
        core_rst = 1'b1;
        if (tmo_expired) begin
          state_next    = ST_ERR;
          err_code_next = ERR_TIMEOUT;
        end else if (s_valid && (word_idx == n_instr - CNT_W'(1))) begin
          state_next = (n_data != '0) ? ST_DATA : ST_START;
        end
      end

      ST_DATA: begin
        busy     = 1'b1;
        core_rst = 1'b1;
        if (tmo_expired) begin
          state_next    = ST_ERR;
          err_code_next = ERR_TIMEOUT;
        end else if (s_valid && (word_idx == n_data - CNT_W'(1))) begin
          state_next = ST_START;
        end
      end

      ST_START: begin
        // First START cycle releases core_rst only; core_start follows for
        // START_HOLD cycles so the two never change on the same edge.
        busy       = 1'b1;
        core_start = (hold_cnt != '0);
        if (hold_cnt == HOLD_W'(START_HOLD)) state_next = ST_DONE;
      end

      ST_DONE: begin
        done = 1'b1;
        if (load_req) state_next = ST_HDR;
      end

      ST_ERR: begin
        err      = 1'b1;
        core_rst = 1'b1;
        if (load_req) state_next = ST_HDR;
      end

      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_instr    <= '0;
      n_data     <= '0;
      word_idx   <= '0;
      hold_cnt   <= '0;
      err_code   <= ERR_NONE;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
    end else begin
      imem_we <= 1'b0;
      dmem_we <= 1'b0;

      // Index restarts at every section boundary so both sections count from 0.
      if (state_next != state) begin
        word_idx <= '0;
      end else if (accept) begin
        word_idx <= word_idx + CNT_W'(1);
      end

      if ((state == ST_HDR) && accept) begin
        n_instr <= hdr_in.n_instr;
        n_data  <= hdr_in.n_data;
      end

      // Address/data registers only load with a write, so they hold the last
      // written value while we is low.
      if ((state == ST_INSTR) && accept) begin
        imem_we    <= 1'b1;
        imem_addr  <= 32'(word_idx);
        imem_wdata <= s_data;
      end

      if ((state == ST_DATA) && accept) begin
        dmem_we    <= 1'b1;
        dmem_addr  <= 32'(DATA_BASE) + 32'(word_idx);
        dmem_wdata <= s_data;
      end

      hold_cnt <= (state == ST_START) ? hold_cnt + HOLD_W'(1) : '0;

      if (load_req &&
          ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR))) begin
        err_code <= ERR_NONE;
      end else if ((state_next == ST_ERR) && (state != ST_ERR)) begin
        err_code <= err_code_next;
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

  localparam int unsigned IMEM_D  = 256;
  localparam int unsigned DMEM_D  = 256;
  localparam int unsigned DBASE   = 32'h40;
  localparam int unsigned TMO     = 64;
  localparam int unsigned HOLD    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_req;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] imem_addr, imem_wdata, dmem_addr, dmem_wdata;
  logic        imem_we, dmem_we, core_rst, core_start, busy, done, err;
  logic [1:0]  err_code;

  program_loader #(
    .IMEM_DEPTH (IMEM_D),
    .DMEM_DEPTH (DMEM_D),
    .DATA_BASE  (DBASE),
    .MAGIC      (8'hA5),
    .TIMEOUT    (TMO),
    .START_HOLD (HOLD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_req   (load_req),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .imem_we    (imem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_we    (dmem_we),
    .core_rst   (core_rst),
    .core_start (core_start),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .err_code   (err_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t imem_q[$];
  wr_t dmem_q[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int wr_total = 0;
  int start_total = 0;
  int wr_cyc[int];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: header classification straight from the frame rules.
  function automatic int exp_code(input logic [31:0] h);
    int ni;
    int nd;
    ni = int'(h[23:12]);
    nd = int'(h[11:0]);
    if (h[31:24] != 8'hA5) return 1;
    if (ni == 0 || ni > int'(IMEM_D) || nd > int'(DMEM_D)) return 2;
    return 0;
  endfunction

  // Monitor: pops the scoreboard on every cache write, watches core_start.
  initial begin
    logic prev_rst;
    wr_t  e;
    prev_rst = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        if (imem_we) begin
          if (imem_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL imem_unexpected addr=0x%0h data=0x%0h t=%0t", imem_addr, imem_wdata, $time);
          end else begin
            e = imem_q.pop_front();
            chk("imem_addr", imem_addr, e.addr);
            chk("imem_wdata", imem_wdata, e.data);
          end
        end
        if (dmem_we) begin
          if (dmem_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL dmem_unexpected addr=0x%0h data=0x%0h t=%0t", dmem_addr, dmem_wdata, $time);
          end else begin
            e = dmem_q.pop_front();
            chk("dmem_addr", dmem_addr, e.addr);
            chk("dmem_wdata", dmem_wdata, e.data);
          end
        end
        if (imem_we || dmem_we) begin
          wr_cyc[wr_total] = cyc;
          wr_total++;
        end
        if (core_start) begin
          start_total++;
          chk("start_core_rst_low", {31'd0, core_rst}, 32'd0);
          chk("start_after_rst_fall", {31'd0, prev_rst}, 32'd0);
        end
      end
      prev_rst = core_rst;
    end
  end

  task automatic pulse_load();
    load_req = 1'b1;
    @(posedge clk); #1;
    load_req = 1'b0;
  endtask

  // Presents one word, optionally after a random idle gap; returns 1ns after the accepting edge.
  task automatic send(input logic [31:0] w, input int max_gap);
    int gap;
    bit ok;
    gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
    if (gap > 0) begin
      s_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
    end
    s_valid = 1'b1;
    s_data  = w;
    ok = 1'b0;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      if (s_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL send_ready_timeout word=0x%0h", w);
    end
  endtask

  task automatic wait_end();
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 500 && !seen; t++) begin
      @(negedge clk);
      if (done || err) seen = 1'b1;
    end
    if (!seen) begin
      checks++; failures++;
      $display("FAIL session_end_timeout done=%0b err=%0b", done, err);
    end
  endtask

  task automatic run_frame(input logic [31:0] hdr, input int max_gap, input bit consec);
    int code, ni, nd, base, n;
    logic [31:0] words[$];
    code = exp_code(hdr);
    ni = int'(hdr[23:12]);
    nd = int'(hdr[11:0]);
    if (code == 0) begin
      for (int i = 0; i < ni + nd; i++) words.push_back($urandom);
      for (int i = 0; i < ni; i++) imem_q.push_back('{addr: 32'(i), data: words[i]});
      for (int i = 0; i < nd; i++) dmem_q.push_back('{addr: DBASE + 32'(i), data: words[ni + i]});
    end
    base = wr_total;
    start_total = 0;
    pulse_load();
    send(hdr, max_gap);
    if (code == 0) begin
      foreach (words[i]) send(words[i], max_gap);
    end
    s_valid = 1'b0;
    wait_end();
    n = wr_total - base;
    chk("done", {31'd0, done}, (code == 0) ? 32'd1 : 32'd0);
    chk("err", {31'd0, err}, (code == 0) ? 32'd0 : 32'd1);
    chk("err_code", {30'd0, err_code}, 32'(code));
    chk("core_rst_end", {31'd0, core_rst}, (code == 0) ? 32'd0 : 32'd1);
    chk("busy_end", {31'd0, busy}, 32'd0);
    chk("start_cycles", 32'(start_total), (code == 0) ? HOLD : 32'd0);
    chk("write_count", 32'(n), (code == 0) ? 32'(ni + nd) : 32'd0);
    chk("imem_q_left", 32'(imem_q.size()), 32'd0);
    chk("dmem_q_left", 32'(dmem_q.size()), 32'd0);
    if (consec && n > 0) chk("write_span", 32'(wr_cyc[wr_total - 1] - wr_cyc[base]), 32'(n - 1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_watchdog");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w0, w1, w2;
    rst = 1'b1; load_req = 1'b0; s_valid = 1'b0; s_data = '0;

    @(negedge clk);
    chk("reset_flags", {22'd0, s_ready, imem_we, dmem_we, core_rst, core_start, busy, done, err, err_code}, 32'd0);
    chk("reset_buses", imem_addr | imem_wdata | dmem_addr | dmem_wdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Back-to-back frame, consecutive writes.
    run_frame(32'hA5003002, 0, 1'b1);
    // Bad magic, then count errors.
    run_frame(32'h5A001000, 0, 1'b0);
    run_frame(32'hA5000004, 0, 1'b0);
    run_frame(32'hA5101000, 0, 1'b0);

    // Timeout after one instruction word.
    w0 = $urandom;
    imem_q.push_back('{addr: 32'd0, data: w0});
    start_total = 0;
    pulse_load();
    send(32'hA5002000, 0);
    send(w0, 0);
    s_valid = 1'b0;
    repeat (TMO) @(negedge clk);
    chk("tmo_not_early", {31'd0, err}, 32'd0);
    @(negedge clk);
    chk("tmo_err", {31'd0, err}, 32'd1);
    chk("tmo_code", {30'd0, err_code}, 32'd3);
    chk("tmo_core_rst", {31'd0, core_rst}, 32'd1);
    chk("tmo_busy", {31'd0, busy}, 32'd0);
    chk("tmo_imem_q_left", 32'(imem_q.size()), 32'd0);
    chk("tmo_no_start", 32'(start_total), 32'd0);
    @(posedge clk); #1;

    // Throttled stream, then a batch of random frames.
    run_frame(32'hA5004000, 3, 1'b0);
    for (int i = 0; i < 6; i++) begin
      int ni, nd;
      ni = int'($urandom_range(1, 8));
      nd = int'($urandom_range(0, 8));
      run_frame({8'hA5, 12'(ni), 12'(nd)}, int'($urandom_range(0, 3)), 1'b0);
    end

    // Reset in the middle of the data section; the data write in flight is lost.
    w0 = $urandom; w1 = $urandom; w2 = $urandom;
    imem_q.push_back('{addr: 32'd0, data: w0});
    imem_q.push_back('{addr: 32'd1, data: w1});
    pulse_load();
    send(32'hA5002003, 0);
    send(w0, 0);
    send(w1, 0);
    send(w2, 0);
    chk("mid_dmem_we", {31'd0, dmem_we}, 32'd1);
    rst = 1'b1;
    s_valid = 1'b0;
    @(negedge clk);
    chk("midrst_flags", {22'd0, s_ready, imem_we, dmem_we, core_rst, core_start, busy, done, err, err_code}, 32'd0);
    chk("midrst_buses", imem_addr | imem_wdata | dmem_addr | dmem_wdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_frame(32'hA5003002, 0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
